// File: rtl/tmds_channel_decoder_if.sv
// Signal bundle for one TMDS lane decoder: serial input plus the decoded symbol outputs.
// The decoder connects to the slave modport and the lane source connects to the master modport.
interface tmds_channel_decoder_if;
  logic       din;
  logic [7:0] data;
  logic       c0;
  logic       c1;
  logic       blanking;
  logic       valid;
  logic       locked;

  modport master (
    output din,
    input  data,
    input  c0,
    input  c1,
    input  blanking,
    input  valid,
    input  locked
  );

  modport slave (
    input  din,
    output data,
    output c0,
    output c1,
    output blanking,
    output valid,
    output locked
  );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS lane receiver: finds 10-bit symbol alignment by hunting for control tokens,
// then decodes each aligned symbol into a pixel byte or a c0/c1 control pair.
module tmds_channel_decoder #(
  parameter int unsigned LOCK_TOKENS = 4,
  parameter int unsigned MAX_GAP     = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  tmds_channel_decoder_if.slave bus
);

  localparam logic [3:0]  LOCK_N  = 4'(LOCK_TOKENS);
  localparam logic [11:0] GAP_MAX = 12'(MAX_GAP);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [9:0]  sr;
  logic [3:0]  bc;
  logic [3:0]  tok_cnt;
  logic [11:0] gap_cnt;

  logic        is_token;
  logic [1:0]  tok_val;
  logic [7:0]  dec_data;
  logic        boundary;
  logic [3:0]  tok_cnt_inc;

  logic        bc_restart;
  logic        tok_load;
  logic        tok_inc;
  logic        gap_clear;
  logic        gap_inc;
  logic        emit;

  assign boundary    = (bc == 4'd9);
  assign tok_cnt_inc = tok_cnt + 4'd1;

  // sr[0] is the oldest bit (q[0]), sr[9] the newest (q[9]).
  always_comb begin
    is_token = 1'b1;
    tok_val  = 2'b00;
    case (sr)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_token = 1'b0;
    endcase
  end

  always_comb begin
    logic [7:0] d;
    d        = sr[9] ? ~sr[7:0] : sr[7:0];
    dec_data = '0;
    dec_data[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec_data[i] = sr[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    bc_restart = 1'b0;
    tok_load   = 1'b0;
    tok_inc    = 1'b0;
    gap_clear  = 1'b0;
    gap_inc    = 1'b0;
    emit       = 1'b0;
    case (state)
      HUNT: begin
        // Any match re-anchors the symbol phase; this cycle counts as a boundary.
        if (is_token) begin
          state_next = VERIFY;
          bc_restart = 1'b1;
          tok_load   = 1'b1;
        end
      end
      VERIFY: begin
        if (boundary) begin
          if (is_token) begin
            tok_inc = 1'b1;
            if (tok_cnt_inc == LOCK_N) begin
              state_next = LOCKED;
              gap_clear  = 1'b1;
            end
          end else begin
            state_next = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          if (is_token) begin
            gap_clear = 1'b1;
            emit      = 1'b1;
          end else if (gap_cnt == GAP_MAX) begin
            state_next = HUNT;
          end else begin
            gap_inc = 1'b1;
            emit    = 1'b1;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bc      <= '0;
      tok_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      sr <= {bus.din, sr[9:1]};

      if (bc_restart || boundary) begin
        bc <= '0;
      end else begin
        bc <= bc + 4'd1;
      end

      if (tok_load) begin
        tok_cnt <= 4'd1;
      end else if (tok_inc) begin
        tok_cnt <= tok_cnt_inc;
      end

      if (gap_clear) begin
        gap_cnt <= '0;
      end else if (gap_inc) begin
        gap_cnt <= gap_cnt + 12'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.data     <= '0;
      bus.c0       <= 1'b0;
      bus.c1       <= 1'b0;
      bus.blanking <= 1'b1;
      bus.valid    <= 1'b0;
      bus.locked   <= 1'b0;
    end else begin
      bus.valid  <= emit;
      bus.locked <= (state_next == LOCKED);
      if (emit) begin
        if (is_token) begin
          bus.data     <= '0;
          bus.c0       <= tok_val[0];
          bus.c1       <= tok_val[1];
          bus.blanking <= 1'b1;
        end else begin
          bus.data     <= dec_data;
          bus.blanking <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side counterpart of the per-channel TMDS encoder/serializer. It takes one TMDS lane as a serial bit stream, sampled once per clock at the bit rate, and finds 10-bit symbol boundaries by hunting for control tokens. It then decodes each symbol into 8-bit pixel data or the c0/c1 control pair plus blanking. One instance sits behind each deserialised gpdi data lane in a DVI/HDMI sink or a loopback test design.

## Interface

- LOCK_TOKENS, default 4: consecutive control tokens at one phase required to declare lock (range 2..15).
- MAX_GAP, default 4095: maximum consecutive non-token symbols tolerated while locked (fits 12 bits).

- clk  in  1  bit-rate clock; one serial bit sampled per rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  1  serial TMDS bit. Bit order is q[0] first, q[9] last.
- data  out  8  last decoded data byte.
- c0  out  1  last decoded control bit 0 (hsync on the blue lane).
- c1  out  1  last decoded control bit 1 (vsync on the blue lane).
- blanking  out  1  1 = last symbol was a control token, 0 = data symbol.
- valid  out  1  one-cycle strobe; data/c0/c1/blanking updated this cycle.
- locked  out  1  symbol alignment established.

## Operation

- Shift register sr[9:0]:
  - Each edge: sr <= {din, sr[9:1]}.
  - After 10 edges, sr[0] holds q[0] and sr[9] holds q[9].
- Token match (combinational on sr):
  - 10'b1101010100 → c1c0 = 00
  - 10'b0010101011 → c1c0 = 01
  - 10'b0101010100 → c1c0 = 10
  - 10'b1010101011 → c1c0 = 11
- Bit counter bc (0..9):
  - Increments mod 10 every edge.
  - A cycle with bc==9 is a boundary cycle, in which sr holds one complete symbol.
- FSM states: HUNT, VERIFY, LOCKED.
  - HUNT:
    - Every cycle, test sr.
    - On a match: bc <= 0, tok_cnt <= 1, go to VERIFY. The match cycle is itself treated as a boundary.
  - VERIFY, acting at boundaries only:
    - If the symbol is a token: tok_cnt <= tok_cnt+1. When tok_cnt+1 == LOCK_TOKENS, go to LOCKED and reset gap_cnt to 0.
    - If the symbol is not a token: go to HUNT. No token test is made in that cycle; hunting resumes the following cycle.
  - LOCKED, acting at boundaries only:
    - Decode the symbol.
    - Token: gap_cnt <= 0.
    - Data symbol: gap_cnt <= gap_cnt+1.
    - If a data symbol arrives with gap_cnt == MAX_GAP: go to HUNT, do not decode that symbol, and do not assert valid.
- Decode (LOCKED boundaries only; results registered):
  - Token:
    - blanking <= 1.
    - c0/c1 <= token value.
    - data <= 0.
  - Data symbol:
    - d = q[9] ? ~q[7:0] : q[7:0].
    - out[0] = d[0].
    - For i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
    - data <= out.
    - blanking <= 0.
    - c0/c1 hold their values.
- locked = (state == LOCKED), registered.
- In HUNT and VERIFY, valid stays 0 and data/c0/c1/blanking hold their values.

## Timing

- Reset values:
  - sr = 0 (not a token).
  - bc = 0, state = HUNT, tok_cnt = 0, gap_cnt = 0.
  - data = 0, c0 = 0, c1 = 0, blanking = 1, valid = 0, locked = 0.
- Latency:
  - Let edge E sample q[9]. The cycle after E is the boundary cycle.
  - Outputs are registered at edge E+1, so valid is high for exactly the one cycle after E+1.
- Decode throughput: at most one valid per 10 cycles, never two in adjacent cycles.
- Lock timing:
  - locked rises in the cycle after the edge that follows the boundary containing the LOCK_TOKENS-th token.
  - The first valid comes from the next boundary.
- Simultaneous events: a token that completes lock is not itself output. Only symbols at boundaries while the FSM is in LOCKED are decoded.
- rst mid-operation overrides everything. All state and outputs return to reset values at that edge, including dropping a pending valid.

## Test plan

- **Reset:** hold rst for 3 cycles with din toggling → data=0, c0=c1=0, blanking=1, valid=0, locked=0.
- **Lock at offset:** send 3 random bits, then ≥4 tokens 10'b1101010100, then continuous token 10'b1010101011 → locked=1 after the 4th token; following valid strobes spaced exactly 10 cycles apart with blanking=1, c0=1, c1=1.
- **Data decode:** after lock, send 10'b0100000000, 10'b0011111111, 10'b1100000000 → data 0x00, 0xFF, 0x01 with blanking=0; c0/c1 unchanged; each valid 2 edges after the symbol's q[9] edge.
- **False lock rejection:** send 2 tokens, then 10'b0100000000 at the same phase → FSM returns to HUNT, locked stays 0, valid never asserted.
- **Gap timeout (MAX_GAP=8):** lock, then send 9 data symbols → 8 valid strobes; locked falls after the 9th, with no valid for it.
- **Reset mid-lock:** assert rst for 1 cycle while locked during a data symbol → reset values next cycle; relock requires 4 fresh tokens.
